// File: rtl/mpu_matrix_loader.sv
// Assembles a flattened DIM x DIM signed matrix from a valid/ready element stream,
// optionally transposing on load, and holds it until the consumer takes it.
module mpu_matrix_loader #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_clear,
  input  logic                        i_transpose,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic [ELEM_W-1:0]           i_in_data,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [ELEM_W*DIM*DIM-1:0]   o_matrix_out,
  output logic                        o_busy,
  output logic [1:0]                  o_dbg_state
);

  // Handshakes: an element transfers on a rising edge with i_in_valid && o_in_ready;
  // the matrix transfers on a rising edge with o_out_valid && i_out_ready.

  localparam int CNT_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int IDX_W = (DIM > 1) ? $clog2(DIM * DIM) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_next_state;
  logic [CNT_W-1:0]            r_row;
  logic [CNT_W-1:0]            r_col;
  logic                        r_tmode;
  logic [ELEM_W*DIM*DIM-1:0]   r_matrix;

  logic                        w_accept;
  logic                        w_last;
  logic                        w_tsel;
  logic [IDX_W-1:0]            w_slot;

  assign o_in_ready   = !i_rst && !i_clear && (r_state != HOLD);
  assign w_accept     = i_in_valid && o_in_ready;
  assign w_last       = (r_row == LAST) && (r_col == LAST);
  // The first element of a matrix uses the live transpose input; later ones the latched mode.
  assign w_tsel       = (r_state == IDLE) ? i_transpose : r_tmode;
  assign o_out_valid  = (r_state == HOLD);
  assign o_busy       = (r_state == FILL) || (r_state == HOLD);
  assign o_matrix_out = r_matrix;
  assign o_dbg_state  = r_state;

  always_comb begin
    w_slot = IDX_W'(r_col) + IDX_W'(DIM) * IDX_W'(r_row);
    if (w_tsel) begin
      w_slot = IDX_W'(r_row) + IDX_W'(DIM) * IDX_W'(r_col);
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (i_clear) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_accept) w_next_state = w_last ? HOLD : FILL;
        FILL: if (w_accept && w_last) w_next_state = HOLD;
        HOLD: if (i_out_ready) w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      if (r_col == LAST) begin
        r_col <= '0;
        r_row <= (r_row == LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmode <= 1'b0;
    end else if (w_accept && (r_state == IDLE)) begin
      r_tmode <= i_transpose;
    end
  end

  // Written in place: unwritten slots keep whatever the previous matrix left there.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_matrix <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < DIM * DIM; k++) begin
        if (w_slot == IDX_W'(k)) begin
          r_matrix[k*ELEM_W +: ELEM_W] <= i_in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Randomized bench for mpu_matrix_loader: an index-arithmetic matrix model feeds a
// scoreboard queue that a separate monitor drains whenever the loader presents a matrix.
module tb_mpu_matrix_loader;

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_clear = 1'b0;
  logic         i_transpose = 1'b0;
  logic         i_in_valid = 1'b0;
  logic [7:0]   i_in_data = 8'h00;
  logic         i_out_ready;
  logic         o_in_ready;
  logic         o_out_valid;
  logic [199:0] o_matrix_out;
  logic         o_busy;
  logic [1:0]   o_dbg_state;

  int checks = 0;
  int failures = 0;

  logic [199:0] exp_q[$];

  // Reference model state
  logic [7:0] mem[25];
  int         m_n = 0;
  bit         m_hold = 0;
  bit         m_tmode = 0;
  bit         m_acc = 0;
  bit         seen = 0;
  int         or_mode = 1;   // 0: out_ready low, 1: high, 2: random

  always #5 clk = ~clk;

  mpu_matrix_loader #(.ELEM_W(8), .DIM(5)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_clear      (i_clear),
    .i_transpose  (i_transpose),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_in_data    (i_in_data),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_matrix_out (o_matrix_out),
    .o_busy       (o_busy),
    .o_dbg_state  (o_dbg_state)
  );

  function automatic logic [199:0] pack_mem();
    logic [199:0] v;
    v = '0;
    for (int k = 0; k < 25; k++) v[k*8 +: 8] = mem[k];
    return v;
  endfunction

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Out-ready driver
  always @(negedge clk) begin
    case (or_mode)
      0: i_out_ready = 1'b0;
      1: i_out_ready = 1'b1;
      default: i_out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Behavioural model: element n lands at row n/5, col n%5, mirrored when transposing.
  always @(posedge clk) begin
    int r, c, slot;
    if (i_rst) begin
      m_n = 0; m_hold = 0; m_tmode = 0; m_acc = 0;
      for (int k = 0; k < 25; k++) mem[k] = 8'h00;
    end else if (i_clear) begin
      m_n = 0; m_hold = 0; m_acc = 0;
    end else if (m_hold) begin
      m_acc = 0;
      if (i_out_ready) m_hold = 0;
    end else if (i_in_valid) begin
      m_acc = 1;
      if (m_n == 0) m_tmode = i_transpose;
      r = m_n / 5;
      c = m_n % 5;
      slot = m_tmode ? (r + 5 * c) : (c + 5 * r);
      mem[slot] = i_in_data;
      m_n++;
      if (m_n == 25) begin
        m_n = 0;
        m_hold = 1;
        exp_q.push_back(pack_mem());
      end
    end else begin
      m_acc = 0;
    end
  end

  // Monitor / scoreboard
  always @(posedge clk) begin
    #1;
    check("in_ready", 200'(o_in_ready), 200'(!i_rst && !i_clear && !m_hold));
    check("out_valid", 200'(o_out_valid), 200'(m_hold));
    check("busy", 200'(o_busy), 200'(m_hold || (m_n > 0)));
    check("matrix_live", o_matrix_out, pack_mem());
    if (o_out_valid && !seen) begin
      seen = 1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty actual=out_valid expected=no_matrix_pending");
      end else begin
        check("sb_matrix", o_matrix_out, exp_q.pop_front());
      end
    end
    if (!o_out_valid) seen = 0;
  end

  // Driver tasks (called at a negedge, return at a negedge)
  task automatic send(input logic [7:0] d, input logic tr, input int gap_max);
    int g;
    int budget;
    g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    repeat (g) begin
      i_in_valid = 1'b0;
      @(negedge clk);
    end
    i_in_valid  = 1'b1;
    i_in_data   = d;
    i_transpose = tr;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!m_acc && budget < 200);
    if (!m_acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted");
    end
    i_in_valid = 1'b0;
  endtask

  task automatic send_count(input int first, input int count, input int tmode, input int gap_max);
    for (int i = 0; i < count; i++) begin
      logic tr;
      tr = (tmode == 2) ? 1'($urandom_range(0, 1)) : (tmode == 1) ? (i % 2 == 0) : 1'b0;
      send(8'(first + i), tr, gap_max);
    end
  endtask

  task automatic do_reset(input int cycles);
    i_rst = 1'b1;
    repeat (cycles) @(negedge clk);
    i_rst = 1'b0;
  endtask

  task automatic idle(input int cycles);
    i_in_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    do_reset(3);
    check("reset_matrix", o_matrix_out, '0);
    idle(2);

    // Row-major
    or_mode = 1;
    send_count(1, 25, 0, 0);
    check("t1_byte1", 200'(o_matrix_out[15:8]), 200'(8'd2));
    check("t1_byte5", 200'(o_matrix_out[47:40]), 200'(8'd6));
    idle(3);

    // Transpose latched at n=0, later toggles ignored
    send_count(1, 25, 1, 0);
    check("t2_byte1", 200'(o_matrix_out[15:8]), 200'(8'd6));
    check("t2_byte5", 200'(o_matrix_out[47:40]), 200'(8'd2));
    check("t2_diag", 200'(o_matrix_out[199:192]), 200'(8'd25));
    idle(3);

    // Backpressure: extra valid elements must be refused while holding
    or_mode = 0;
    idle(1);
    send_count(40, 25, 0, 0);
    i_in_valid = 1'b1;
    i_in_data  = 8'hEE;
    repeat (10) @(negedge clk);
    i_in_valid = 1'b0;
    or_mode = 1;
    idle(3);
    send_count(70, 25, 0, 0);
    idle(3);

    // Signed values with random stalls
    send(8'h80, 1'b0, 3);
    send(8'h7F, 1'b0, 3);
    send(8'hFF, 1'b0, 3);
    for (int i = 3; i < 25; i++) send(8'($urandom), 1'b0, 3);
    check("t4_b0", 200'(o_matrix_out[7:0]), 200'(8'h80));
    check("t4_b1", 200'(o_matrix_out[15:8]), 200'(8'h7F));
    check("t4_b2", 200'(o_matrix_out[23:16]), 200'(8'hFF));
    idle(3);

    // Clear mid-fill with an element offered in the same cycle
    send_count(100, 12, 0, 0);
    i_clear    = 1'b1;
    i_in_valid = 1'b1;
    i_in_data  = 8'h99;
    @(negedge clk);
    i_clear    = 1'b0;
    i_in_valid = 1'b0;
    idle(2);
    send_count(150, 25, 2, 1);
    idle(3);

    // Reset mid-fill and mid-hold
    send_count(10, 12, 0, 0);
    do_reset(2);
    check("t6_fill_rst", o_matrix_out, '0);
    or_mode = 0;
    idle(1);
    send_count(30, 25, 0, 0);
    idle(2);
    do_reset(2);
    check("t6_hold_rst", o_matrix_out, '0);
    or_mode = 1;
    idle(2);

    // Randomized matrices with random consumer readiness and occasional clear
    or_mode = 2;
    for (int m = 0; m < 6; m++) begin
      for (int i = 0; i < 25; i++) send(8'($urandom), 1'($urandom_range(0, 1)), 2);
      if (m == 3) begin
        send_count(5, 7, 2, 0);
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
      end
    end
    or_mode = 1;
    idle(6);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
